// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// {cout, s} = a + b + cin, delivered WIDTH+1 cycles after start.
module somador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sum_bit;
    logic              maj;

    always_comb begin
        sum_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
        maj     = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) |
                  (opb_q[0] & carry_q);

        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE accepts start like IDLE for back-to-back operation
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = maj;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    cout_d  = maj;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial (WIDTH=8): vector table plus
// multi-cycle sequences for ignored start, streaming and mid-op reset.
module tb_somador_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       cout;

    int n_cmp;
    int n_fail;

    somador_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, output logic [7:0] rs,
                         output logic rc, output int nbusy);
        logic [7:0] s_before;
        logic       c_before;
        bit         seen;
        @(negedge clk);
        s_before = s;
        c_before = cout;
        start = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va;
        b = ~vb;
        cin = ~vc;
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (s !== s_before || cout !== c_before) begin
                check("s_stable_busy", {23'd0, cout, s},
                      {23'd0, c_before, s_before});
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        rs = s;
        rc = cout;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [7:0] rs;
        logic       rc;
        int         nb;
        int         ndone;
        int         last;
        int         nbz;

        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9]  = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1};
        vecs[10] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
        vecs[11] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
        vecs[12] = '{8'h99, 8'h66, 1'b0, 8'hFF, 1'b0};
        vecs[13] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
        vecs[14] = '{8'h64, 8'h32, 1'b0, 8'h96, 1'b0};
        vecs[15] = '{8'hFE, 8'hFE, 1'b0, 8'hFC, 1'b1};
        vecs[16] = '{8'h55, 8'h55, 1'b1, 8'hAB, 1'b0};
        vecs[17] = '{8'hE7, 8'h19, 1'b0, 8'h00, 1'b1};
        vecs[18] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[19] = '{8'h23, 8'h45, 1'b1, 8'h69, 1'b0};

        #23;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s", {24'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, nb);
            check($sformatf("vec%0d_s", i), {24'd0, rs}, {24'd0, vecs[i].s});
            check($sformatf("vec%0d_cout", i), {31'd0, rc},
                  {31'd0, vecs[i].cout});
            check($sformatf("vec%0d_busy_cycles", i), nb, 32'd8);
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
        end
        check("ign_ndone", ndone, 32'd1);
        check("ign_s", {24'd0, s}, 32'h30);
        check("ign_cout", {31'd0, cout}, 32'd0);
        check("ign_idle", {30'd0, busy, done}, 32'd0);

        // start held high: one result every 9 cycles
        @(negedge clk);
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        @(posedge clk);
        ndone = 0;
        last = -1;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            check($sformatf("stream_busy%0d", i), {31'd0, busy},
                  {31'd0, ~done});
            if (done) begin
                check("stream_s", {24'd0, s}, 32'h03);
                check("stream_cout", {31'd0, cout}, 32'd0);
                if (last >= 0) check("stream_period", i - last, 32'd9);
                last = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("stream_ndone", ndone, 32'd3);
        check("stream_last_idx", last, 32'd27);

        // reset in the middle of an operation
        do_op(8'h5A, 8'h3C, 1'b0, rs, rc, nb);
        check("pre_rst_s", {24'd0, rs}, 32'h96);
        @(negedge clk);
        start = 1'b1;
        a = 8'h0F;
        b = 8'h0F;
        cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_s", {24'd0, s}, 32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nbz = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) nbz++;
        end
        check("post_rst_quiet", nbz, 32'd0);
        check("post_rst_s", {24'd0, s}, 32'd0);
        do_op(8'h0F, 8'h0F, 1'b0, rs, rc, nb);
        check("post_rst_op_s", {24'd0, rs}, 32'h1E);
        check("post_rst_op_cout", {31'd0, rc}, 32'd0);
        check("post_rst_op_busy", nb, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
